// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC owner, single-outstanding imem requester, in-order prefetch queue.
// Optional build macro FETCH_HLT_DECODE_EN: stop fetching after a queued word whose top nibble is HLT_OPCODE.
module fetch_unit #(
  parameter int              DATA_W     = 16,
  parameter int              DEPTH      = 4,
  parameter int              PC_STEP    = 2,
  parameter logic [DATA_W-1:0] RESET_PC = '0,
  parameter logic [3:0]      HLT_OPCODE = 4'hF
) (
  input  logic              clk,
  input  logic              rst,
  output logic              imem_req,
  output logic [DATA_W-1:0] imem_addr,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic              instr_valid,
  output logic [DATA_W-1:0] instr,
  output logic [DATA_W-1:0] instr_pc,
  input  logic              instr_ready,
  input  logic              redirect,
  input  logic [DATA_W-1:0] redirect_pc,
  input  logic              halt,
  output logic              halted
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0]  DEPTH_C = CNT_W'(DEPTH);
  localparam logic [PTR_W-1:0]  LAST_P  = PTR_W'(DEPTH - 1);
  localparam logic [DATA_W-1:0] PC_INC  = DATA_W'(PC_STEP);

  typedef struct packed {
    logic [DATA_W-1:0] instr;
    logic [DATA_W-1:0] pc;
  } entry_t;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DRAIN} state_t;

  state_t            state, state_nxt;
  entry_t            q [DEPTH];
  logic [PTR_W-1:0]  rd_ptr, wr_ptr;
  logic [CNT_W-1:0]  count, count_nxt;
  logic [DATA_W-1:0] fetch_pc, pc_inc;
  logic              push, pop, slot_free, issue;
  logic              self_halt, hlt_hit;

  function automatic logic [PTR_W-1:0] ptr_nxt(input logic [PTR_W-1:0] p);
    return (p == LAST_P) ? '0 : p + 1'b1;
  endfunction

  // fetch_pc always equals the outstanding address while in WAIT, so it tags the pushed word.
  assign push      = (state == S_WAIT) && imem_rvalid && !redirect;
  assign pop       = instr_valid && instr_ready && !redirect;
  assign count_nxt = count + CNT_W'(push) - CNT_W'(pop);
  assign slot_free = (state == S_IDLE) || imem_rvalid;
  assign pc_inc    = fetch_pc + PC_INC;

  assign instr_valid = (count != '0);
  assign instr       = q[rd_ptr].instr;
  assign instr_pc    = q[rd_ptr].pc;

`ifdef FETCH_HLT_DECODE_EN
  logic self_halt_q;
  assign hlt_hit   = push && (imem_rdata[DATA_W-1 -: 4] == HLT_OPCODE);
  assign self_halt = self_halt_q;

  always_ff @(posedge clk) begin
    if (rst || redirect) self_halt_q <= 1'b0;
    else if (hlt_hit)    self_halt_q <= 1'b1;
  end
`else
  logic unused_hlt_opcode;
  assign unused_hlt_opcode = ^HLT_OPCODE;
  assign hlt_hit   = 1'b0;
  assign self_halt = 1'b0;
`endif

  // FSM: state register
  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  state_nxt = issue ? S_WAIT : S_IDLE;
      S_WAIT: begin
        if (imem_rvalid)   state_nxt = issue ? S_WAIT : S_IDLE;
        else if (redirect) state_nxt = S_DRAIN;
      end
      S_DRAIN: if (imem_rvalid) state_nxt = issue ? S_WAIT : S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // FSM: outputs. A slot is reserved at issue time, so a later push never overflows.
  always_comb begin
    issue     = !rst && slot_free && !redirect && !halt && !self_halt && !hlt_hit &&
                (count_nxt < DEPTH_C);
    imem_req  = issue;
    imem_addr = issue ? (push ? pc_inc : fetch_pc) : '0;
    halted    = !rst && (halt || self_halt) && (state == S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst)           fetch_pc <= RESET_PC;
    else if (redirect) fetch_pc <= redirect_pc;
    else if (push)     fetch_pc <= pc_inc;
  end

  always_ff @(posedge clk) begin
    if (rst || redirect) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= ptr_nxt(wr_ptr);
      if (pop)  rd_ptr <= ptr_nxt(rd_ptr);
      count <= count_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (push) q[wr_ptr] <= '{instr: imem_rdata, pc: fetch_pc};
  end

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: table-driven streaming/backpressure run plus redirect, halt, wrap and HLT sequences.
module tb_fetch_unit;
  logic        clk = 1'b0;
  logic        rst, imem_req, imem_rvalid, instr_valid, instr_ready, redirect, halt, halted;
  logic [15:0] imem_addr, imem_rdata, instr, instr_pc, redirect_pc;

  fetch_unit dut (
    .clk(clk), .rst(rst), .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_rvalid(imem_rvalid), .imem_rdata(imem_rdata), .instr_valid(instr_valid),
    .instr(instr), .instr_pc(instr_pc), .instr_ready(instr_ready), .redirect(redirect),
    .redirect_pc(redirect_pc), .halt(halt), .halted(halted)
  );

  always #5 clk = ~clk;

  int nchk = 0, nerr = 0;
  // memory model state
  int          lat = 1;
  logic        pv = 1'b0, inject = 1'b0;
  logic [15:0] pa = '0, hlt_at = 16'hFFFF;
  int          pcnt = 0;
  // sampled outputs
  logic        s_req, s_valid, s_halted;
  logic [15:0] s_addr, s_instr, s_pc;

  typedef struct {
    logic        ready;
    logic        req;
    logic [15:0] addr;
    logic        valid;
    logic [15:0] pc;
  } vec_t;
  vec_t tbl [15];

  function automatic logic [15:0] memf(input logic [15:0] a);
    if (a == hlt_at) return 16'hF000;
    return {4'h1, a[11:0]};
  endfunction

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    nchk++;
    if (got !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  // One clock cycle: called just after a negedge with this cycle's inputs already set.
  task automatic tick();
    if (inject) begin
      imem_rvalid = 1'b1; imem_rdata = 16'hDEAD; inject = 1'b0;
    end else if (pv && pcnt == 0) begin
      imem_rvalid = 1'b1; imem_rdata = memf(pa); pv = 1'b0;
    end else begin
      imem_rvalid = 1'b0; imem_rdata = 16'h0;
      if (pv) pcnt--;
    end
    #1;
    s_req = imem_req; s_addr = imem_addr; s_valid = instr_valid;
    s_instr = instr; s_pc = instr_pc; s_halted = halted;
    if (imem_req) begin
      pv = 1'b1; pa = imem_addr; pcnt = lat - 1;
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1; halt = 1'b0; redirect = 1'b0; redirect_pc = '0; instr_ready = 1'b0;
    pv = 1'b0;
    tick();
    tick();
    chk("rst_req", s_req, 0);
    chk("rst_addr", s_addr, 0);
    chk("rst_valid", s_valid, 0);
    chk("rst_halted", s_halted, 0);
    rst = 1'b0; pv = 1'b0;
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    logic seen, stale;
    rst = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
    instr_ready = 1'b0; redirect = 1'b0; redirect_pc = '0; halt = 1'b0;

    tbl[0]  = '{1'b1, 1'b1, 16'h0000, 1'b0, 16'h0000};
    tbl[1]  = '{1'b1, 1'b1, 16'h0002, 1'b0, 16'h0000};
    tbl[2]  = '{1'b1, 1'b1, 16'h0004, 1'b1, 16'h0000};
    tbl[3]  = '{1'b1, 1'b1, 16'h0006, 1'b1, 16'h0002};
    tbl[4]  = '{1'b0, 1'b1, 16'h0008, 1'b1, 16'h0004};
    tbl[5]  = '{1'b0, 1'b1, 16'h000A, 1'b1, 16'h0004};
    tbl[6]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0004};
    tbl[7]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0004};
    tbl[8]  = '{1'b0, 1'b0, 16'h0000, 1'b1, 16'h0004};
    tbl[9]  = '{1'b1, 1'b1, 16'h000C, 1'b1, 16'h0004};
    tbl[10] = '{1'b1, 1'b1, 16'h000E, 1'b1, 16'h0006};
    tbl[11] = '{1'b1, 1'b1, 16'h0010, 1'b1, 16'h0008};
    tbl[12] = '{1'b1, 1'b1, 16'h0012, 1'b1, 16'h000A};
    tbl[13] = '{1'b1, 1'b1, 16'h0014, 1'b1, 16'h000C};
    tbl[14] = '{1'b1, 1'b1, 16'h0016, 1'b1, 16'h000E};

    @(negedge clk);

    // Streaming at latency 1, then queue fill under backpressure; a stray rvalid comes with the first cycle.
    lat = 1;
    do_reset();
    inject = 1'b1;
    for (int i = 0; i < 15; i++) begin
      instr_ready = tbl[i].ready;
      tick();
      chk($sformatf("tbl%0d_req", i), s_req, tbl[i].req);
      chk($sformatf("tbl%0d_addr", i), s_addr, tbl[i].addr);
      chk($sformatf("tbl%0d_valid", i), s_valid, tbl[i].valid);
      if (tbl[i].valid) begin
        chk($sformatf("tbl%0d_pc", i), s_pc, tbl[i].pc);
        chk($sformatf("tbl%0d_instr", i), s_instr, memf(tbl[i].pc));
      end
      chk($sformatf("tbl%0d_halted", i), s_halted, 0);
    end

    // Latency 3, redirect while 0x0006 is outstanding.
    lat = 3;
    do_reset();
    instr_ready = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin
      tick();
      if (s_req && s_addr == 16'h0006) seen = 1'b1;
    end
    chk("t3_req6_seen", seen, 1);
    tick();
    redirect = 1'b1; redirect_pc = 16'h0100;
    tick();
    chk("t3_redir_noreq", s_req, 0);
    redirect = 1'b0;
    tick();
    chk("t3_drain_req", s_req, 1);
    chk("t3_drain_addr", s_addr, 16'h0100);
    chk("t3_drain_valid", s_valid, 0);
    seen = 1'b0; stale = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      tick();
      if (s_valid) begin
        seen = 1'b1;
        if (s_pc != 16'h0100) stale = 1'b1;
      end
    end
    chk("t3_first_valid_seen", seen, 1);
    chk("t3_no_stale", stale, 0);
    chk("t3_first_pc", s_pc, 16'h0100);
    chk("t3_first_instr", s_instr, memf(16'h0100));

    // Redirect coinciding with rvalid and a pop.
    lat = 1;
    do_reset();
    instr_ready = 1'b1;
    for (int i = 0; i < 4; i++) tick();
    redirect = 1'b1; redirect_pc = 16'h0040;
    tick();
    chk("t4_redir_valid_before", s_valid, 1);
    chk("t4_redir_noreq", s_req, 0);
    redirect = 1'b0;
    tick();
    chk("t4_valid_after", s_valid, 0);
    chk("t4_req_after", s_req, 1);
    chk("t4_addr_after", s_addr, 16'h0040);
    tick();
    chk("t4_valid_c6", s_valid, 0);
    tick();
    chk("t4_valid_c7", s_valid, 1);
    chk("t4_pc_c7", s_pc, 16'h0040);

    // Halt with one request outstanding at latency 3.
    lat = 3;
    do_reset();
    instr_ready = 1'b1;
    tick();
    chk("t5_req0", s_req, 1);
    halt = 1'b1;
    tick();
    chk("t5_c1_noreq", s_req, 0);
    chk("t5_c1_halted", s_halted, 0);
    tick();
    tick();
    chk("t5_c3_noreq", s_req, 0);
    chk("t5_c3_halted", s_halted, 0);
    tick();
    chk("t5_c4_halted", s_halted, 1);
    chk("t5_c4_valid", s_valid, 1);
    chk("t5_c4_pc", s_pc, 16'h0000);
    chk("t5_c4_noreq", s_req, 0);
    tick();
    chk("t5_c5_halted", s_halted, 1);
    chk("t5_c5_drained", s_valid, 0);
    halt = 1'b0;
    tick();
    chk("t5_resume_req", s_req, 1);
    chk("t5_resume_addr", s_addr, 16'h0002);
    chk("t5_resume_halted", s_halted, 0);

    // PC wraps modulo 2^16.
    lat = 1;
    do_reset();
    instr_ready = 1'b1;
    tick();
    redirect = 1'b1; redirect_pc = 16'hFFFC;
    tick();
    redirect = 1'b0;
    tick();
    chk("t7_addr_fffc", s_addr, 16'hFFFC);
    tick();
    chk("t7_addr_fffe", s_addr, 16'hFFFE);
    tick();
    chk("t7_wrap_req", s_req, 1);
    chk("t7_wrap_addr", s_addr, 16'h0000);

    // HLT word at 0x0008.
    lat = 1;
    hlt_at = 16'h0008;
    do_reset();
    instr_ready = 1'b1;
    for (int i = 0; i < 5; i++) tick();
    tick();
`ifdef FETCH_HLT_DECODE_EN
    chk("t6_no_req_000a", s_req, 0);
`else
    chk("t6_req_000a", s_req, 1);
    chk("t6_addr_000a", s_addr, 16'h000A);
`endif
    tick();
    chk("t6_hlt_valid", s_valid, 1);
    chk("t6_hlt_pc", s_pc, 16'h0008);
    chk("t6_hlt_instr", s_instr, 16'hF000);
`ifdef FETCH_HLT_DECODE_EN
    chk("t6_halted", s_halted, 1);
    chk("t6_halted_noreq", s_req, 0);
`else
    chk("t6_not_halted", s_halted, 0);
`endif
    redirect = 1'b1; redirect_pc = 16'h0020;
    tick();
    chk("t6_redir_noreq", s_req, 0);
    redirect = 1'b0;
    tick();
    chk("t6_restart_req", s_req, 1);
    chk("t6_restart_addr", s_addr, 16'h0020);
    chk("t6_restart_halted", s_halted, 0);
    hlt_at = 16'hFFFF;

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end
endmodule
